// File: rtl/lt_sequencer_pkg.sv
// Shared encodings for the latency-test sequencer: FSM state codes and patch positions.
package lt_sequencer_pkg;

   // Legacy-compatible state codes, also visible on the debug port.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_FLASH  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   typedef enum logic [1:0] {
      LT_POS_CENTER = 2'd0,
      LT_POS_LEFT   = 2'd1,
      LT_POS_RIGHT  = 2'd2,
      LT_POS_TOP    = 2'd3
   } lt_pos_e;

   // VSYNC is active low, so a frame begins on its falling edge.
   function automatic logic frame_edge(input logic prev, input logic cur);
      return prev & ~cur;
   endfunction

endpackage

// File: rtl/lt_sequencer_if.sv
// Control/result bundle between UI + video generator (master) and the sequencer (slave).
interface lt_sequencer_if #(
   parameter int LAT_W = 16
);
   // start is a one-cycle request with no ready: it is taken only while busy is
   // low, and busy stays high until the result flags are final.
   logic             start;
   logic [1:0]       mode_sel;
   logic             vsync_in;
   logic             sensor_in;
   logic             lt_active;
   logic [1:0]       lt_mode;
   logic             busy;
   logic             result_valid;
   logic             timeout;
   logic             sensor_err;
   logic [LAT_W-1:0] latency;

   modport master (
      output start, mode_sel, vsync_in, sensor_in,
      input  lt_active, lt_mode, busy, result_valid, timeout, sensor_err, latency
   );

   modport slave (
      input  start, mode_sel, vsync_in, sensor_in,
      output lt_active, lt_mode, busy, result_valid, timeout, sensor_err, latency
   );
endinterface

// File: rtl/lt_sensor_sync.sv
// Photodiode input conditioning: 2-flop synchronizer, rising-edge detect and a
// run-length debounce that qualifies a hit after DEBOUNCE consecutive high samples.
module lt_sensor_sync #(
   parameter int DEBOUNCE = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sensor_i,
   output logic rise_pulse_o,
   output logic qualified_pulse_o,
   output logic qualified_o
);

   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] RUN_LAST = CW'(DEBOUNCE - 1);
   localparam logic [CW-1:0] RUN_SAT  = CW'(DEBOUNCE);

   logic          sync1_q, sync2_q, prev_q;
   logic [CW-1:0] run_q, run_d;

   // run_q counts highs seen before the current sample, saturating at DEBOUNCE.
   always_comb begin
      run_d = run_q;
      if (!sync2_q) begin
         run_d = '0;
      end else if (run_q != RUN_SAT) begin
         run_d = run_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         run_q   <= '0;
      end else begin
         sync1_q <= sensor_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         run_q   <= run_d;
      end
   end

   assign rise_pulse_o      = sync2_q & ~prev_q;
   assign qualified_pulse_o = sync2_q & (run_q == RUN_LAST);
   assign qualified_o       = sync2_q & (run_q >= RUN_LAST);

endmodule

// File: rtl/lt_sequencer.sv
// One latency measurement per start: dark settle, frame-aligned white patch, then
// microsecond timing of the photodiode response with timeout.
module lt_sequencer
   import lt_sequencer_pkg::*;
#(
   parameter int CLK_PER_US    = 27,
   parameter int SETTLE_FRAMES = 4,
   parameter int TIMEOUT_US    = 65000,
   parameter int DEBOUNCE      = 8,
   parameter int LAT_W         = 16
) (
   input  logic                clk27,
   input  logic                reset_n,
   lt_sequencer_if.slave       bus,
   output logic [1:0]          dbg_state_o
);

   localparam logic [4:0]       PRESC_MAX = 5'(CLK_PER_US - 1);
   localparam logic [3:0]       SETTLE_N  = 4'(SETTLE_FRAMES);
   localparam logic [LAT_W-1:0] TO_VAL    = LAT_W'(TIMEOUT_US);
   localparam logic [LAT_W-1:0] US_SAT    = {LAT_W{1'b1}};

   logic [1:0]       state_q, state_d;
   logic [3:0]       frame_cnt_q, frame_cnt_d;
   logic [4:0]       presc_q, presc_d;
   logic [LAT_W-1:0] us_cnt_q, us_cnt_d;
   logic [LAT_W-1:0] snap_q, snap_d;
   logic [LAT_W-1:0] latency_q, latency_d;
   logic             vsync_prev_q;
   logic             lt_active_q, lt_active_d;
   logic [1:0]       lt_mode_q, lt_mode_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
   logic             err_q, err_d;

   logic             rise_pulse, qual_pulse, qual_level;
   logic             frame_start;

   lt_sensor_sync #(
      .DEBOUNCE (DEBOUNCE)
   ) u_sensor_sync (
      .clk_i             (clk27),
      .rst_ni            (reset_n),
      .sensor_i          (bus.sensor_in),
      .rise_pulse_o      (rise_pulse),
      .qualified_pulse_o (qual_pulse),
      .qualified_o       (qual_level)
   );

   assign frame_start = frame_edge(vsync_prev_q, bus.vsync_in);

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      presc_d     = presc_q;
      us_cnt_d    = us_cnt_q;
      snap_d      = snap_q;
      latency_d   = latency_q;
      lt_active_d = lt_active_q;
      lt_mode_d   = lt_mode_q;
      busy_d      = busy_q;
      valid_d     = valid_q;
      timeout_d   = timeout_q;
      err_d       = err_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               lt_mode_d   = bus.mode_sel;
               valid_d     = 1'b0;
               timeout_d   = 1'b0;
               err_d       = 1'b0;
               busy_d      = 1'b1;
               frame_cnt_d = 4'd0;
               state_d     = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            // The level form catches a sensor that was already lit before start.
            if (qual_level) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (frame_start) begin
               if (frame_cnt_q == SETTLE_N) begin
                  lt_active_d = 1'b1;
                  presc_d     = 5'd0;
                  us_cnt_d    = '0;
                  state_d     = ST_FLASH;
               end else begin
                  frame_cnt_d = frame_cnt_q + 4'd1;
               end
            end
         end

         ST_FLASH: begin
            if (presc_q == PRESC_MAX) begin
               presc_d = 5'd0;
               if (us_cnt_q != US_SAT) begin
                  us_cnt_d = us_cnt_q + 1'b1;
               end
            end else begin
               presc_d = presc_q + 5'd1;
            end

            if (rise_pulse) begin
               snap_d = us_cnt_q;
            end

            // Latency is the time of the first high sample of the qualifying run.
            if (qual_pulse) begin
               latency_d   = rise_pulse ? us_cnt_q : snap_q;
               valid_d     = 1'b1;
               lt_active_d = 1'b0;
               state_d     = ST_DONE;
            end else if (us_cnt_q >= TO_VAL) begin
               latency_d   = TO_VAL;
               timeout_d   = 1'b1;
               valid_d     = 1'b0;
               lt_active_d = 1'b0;
               state_d     = ST_DONE;
            end
         end

         ST_DONE: begin
            lt_active_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         frame_cnt_q  <= 4'd0;
         presc_q      <= 5'd0;
         us_cnt_q     <= '0;
         snap_q       <= '0;
         latency_q    <= '0;
         vsync_prev_q <= 1'b0;
         lt_active_q  <= 1'b0;
         lt_mode_q    <= LT_POS_CENTER;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         timeout_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_cnt_q  <= frame_cnt_d;
         presc_q      <= presc_d;
         us_cnt_q     <= us_cnt_d;
         snap_q       <= snap_d;
         latency_q    <= latency_d;
         vsync_prev_q <= bus.vsync_in;
         lt_active_q  <= lt_active_d;
         lt_mode_q    <= lt_mode_d;
         busy_q       <= busy_d;
         valid_q      <= valid_d;
         timeout_q    <= timeout_d;
         err_q        <= err_d;
      end
   end

   assign bus.lt_active    = lt_active_q;
   assign bus.lt_mode      = lt_mode_q;
   assign bus.busy         = busy_q;
   assign bus.result_valid = valid_q;
   assign bus.timeout      = timeout_q;
   assign bus.sensor_err   = err_q;
   assign bus.latency      = latency_q;
   assign dbg_state_o      = state_q;

endmodule
